// File: rtl/xor5_frame_assembler.sv
// -----------------------------------------------------------------------------
// xor5_frame_assembler
//
// Purpose:
//   Collects a serial bit stream into 5-bit frames. Each frame is handed to a
//   downstream 5-input parity stage together with its parity bit. The first
//   bit of a frame lands in out_word[0] and the fifth bit in out_word[4].
//   Collection of the next frame overlaps a frame that is still held on the
//   output. Only the fifth bit of the next frame can stall, and it stalls only
//   while the held frame has not been taken.
//
// Parameters:
//   CNT_W      width of the delivered-frame counter (wraps silently)
//   ODD        0 selects even parity, 1 selects odd parity
//
// Ports:
//   clk        single clock, rising-edge
//   rst        synchronous, active-high reset
//   in_bit     serial data bit
//   in_valid   in_bit is valid
//   in_ready   block accepts in_bit this cycle (depends on state and out_ready)
//   flush      discard the partial frame; a held output frame is unaffected
//   out_word   assembled frame, pi0..pi4 = out_word[0..4]
//   out_parity XOR of out_word[4:0] XOR ODD, registered with out_word
//   out_valid  out_word / out_parity are valid
//   out_ready  downstream accepts the frame
//   frame_cnt  number of frames taken by the downstream stage
// -----------------------------------------------------------------------------
module xor5_frame_assembler #(
    parameter int CNT_W = 8,
    parameter bit ODD   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [4:0]       out_word,
    output logic             out_parity,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] frame_cnt
);

    // Parity of a 5-bit frame, optionally inverted for odd parity.
    function automatic logic parity5(input logic [4:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

    // Collection state
    logic [2:0]       r_bit_idx;
    logic [3:0]       r_sr;

    // Output frame registers
    logic [4:0]       r_out_word;
    logic             r_out_parity;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_frame_cnt;

    // Handshake decode
    logic             w_last_bit;
    logic             w_in_ready;
    logic             w_in_acc;
    logic             w_out_acc;
    logic             w_frame_done;
    logic [4:0]       w_next_word;

    // The fifth bit is the only position that has to wait for the output slot.
    assign w_last_bit   = (r_bit_idx == 3'd4);

    // Built from state and out_ready only, so there is no path from in_valid.
    assign w_in_ready   = (!w_last_bit) | (!r_out_valid) | out_ready;

    assign w_in_acc     = in_valid & w_in_ready;
    assign w_out_acc    = r_out_valid & out_ready;

    // A flush in the same cycle discards the bit, so it cannot complete a frame.
    assign w_frame_done = w_in_acc & w_last_bit & (!flush);
    assign w_next_word  = {in_bit, r_sr};

    // Collect index and partial-frame store. A flush rewinds the index without
    // clearing the store. Stale store bits are overwritten before they are used.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_idx <= 3'd0;
            r_sr      <= 4'd0;
        end else if (flush) begin
            r_bit_idx <= 3'd0;
            r_sr      <= r_sr;
        end else if (w_in_acc) begin
            if (w_last_bit) begin
                r_bit_idx <= 3'd0;
                r_sr      <= r_sr;
            end else begin
                r_bit_idx              <= r_bit_idx + 3'd1;
                r_sr[r_bit_idx[1:0]]   <= in_bit;
            end
        end else begin
            r_bit_idx <= r_bit_idx;
            r_sr      <= r_sr;
        end
    end

    // Output frame register. Word and parity load together when a frame
    // completes. A completion in the same cycle as an output accept replaces
    // the old frame with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_word   <= 5'd0;
            r_out_parity <= ODD;
            r_out_valid  <= 1'b0;
        end else if (w_frame_done) begin
            r_out_word   <= w_next_word;
            r_out_parity <= parity5(w_next_word, ODD);
            r_out_valid  <= 1'b1;
        end else if (w_out_acc) begin
            r_out_word   <= r_out_word;
            r_out_parity <= r_out_parity;
            r_out_valid  <= 1'b0;
        end else begin
            r_out_word   <= r_out_word;
            r_out_parity <= r_out_parity;
            r_out_valid  <= r_out_valid;
        end
    end

    // Delivered-frame counter. It wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_out_acc) begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        end else begin
            r_frame_cnt <= r_frame_cnt;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_word   = r_out_word;
    assign out_parity = r_out_parity;
    assign out_valid  = r_out_valid;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_xor5_frame_assembler.sv
// Bench for xor5_frame_assembler. Two instances share the same stimulus:
// d0 uses the defaults (CNT_W=8, even parity), and d1 uses CNT_W=2 with odd parity.
// A queue-based model of the frame rules supplies every expected value.
module tb_xor5_frame_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, in_bit = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;

    logic       d0_in_ready, d0_out_parity, d0_out_valid;
    logic [4:0] d0_out_word;
    logic [7:0] d0_frame_cnt;
    logic       d1_in_ready, d1_out_parity, d1_out_valid;
    logic [4:0] d1_out_word;
    logic [1:0] d1_frame_cnt;

    xor5_frame_assembler #(.CNT_W(8), .ODD(1'b0)) d0 (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(d0_in_ready), .flush(flush), .out_word(d0_out_word),
        .out_parity(d0_out_parity), .out_valid(d0_out_valid),
        .out_ready(out_ready), .frame_cnt(d0_frame_cnt)
    );

    xor5_frame_assembler #(.CNT_W(2), .ODD(1'b1)) d1 (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(d1_in_ready), .flush(flush), .out_word(d1_out_word),
        .out_parity(d1_out_parity), .out_valid(d1_out_valid),
        .out_ready(out_ready), .frame_cnt(d1_frame_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: bits gathered so far, the held frame, and the delivered count.
    bit          m_q[$];
    logic        m_valid = 1'b0;
    logic [4:0]  m_word  = 5'd0;
    int unsigned m_cnt   = 0;

    logic rdy_obs0, rdy_obs1, rdy_exp;

    // One clock cycle: drive inputs, sample in_ready, update the model, then return at the negedge.
    task automatic step(input logic b, input logic v, input logic f, input logic o, input logic r);
        logic acc, oacc;
        rst = r; in_bit = b; in_valid = v; flush = f; out_ready = o;
        #1;
        rdy_obs0 = d0_in_ready;
        rdy_obs1 = d1_in_ready;
        rdy_exp  = (m_q.size() < 4) || !m_valid || o;
        acc  = v && rdy_exp;
        oacc = m_valid && o;
        @(posedge clk);
        if (r) begin
            m_q.delete(); m_valid = 1'b0; m_word = 5'd0; m_cnt = 0;
        end else begin
            if (oacc) m_cnt++;
            if (f) m_q.delete();
            else if (acc) m_q.push_back(b);
            if (!f && acc && m_q.size() == 5) begin
                for (int k = 0; k < 5; k++) m_word[k] = m_q[k];
                m_q.delete();
                m_valid = 1'b1;
            end else if (oacc) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({d0_out_valid, d0_out_word, d0_out_parity, d0_frame_cnt} !== 15'd0) begin
            errors++; $display("FAIL reset_d0 got %h exp 0", {d0_out_valid, d0_out_word, d0_out_parity, d0_frame_cnt});
        end
        checks++;
        if ({d1_out_valid, d1_out_word, d1_out_parity, d1_frame_cnt} !== 9'b0_00000_1_00) begin
            errors++; $display("FAIL reset_d1 got %b exp 000000100", {d1_out_valid, d1_out_word, d1_out_parity, d1_frame_cnt});
        end
        checks++;
        if (rdy_obs0 !== 1'b1 || rdy_obs1 !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b%b exp 11", rdy_obs0, rdy_obs1);
        end
    endtask

    task automatic test_single_frame();
        logic [4:0] pat;
        pat = 5'b01101;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step(pat[k], 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({d0_out_valid, d0_out_word, d0_out_parity} !== {1'b1, 5'b01101, 1'b1}) begin
            errors++; $display("FAIL single_frame got v%b w%b p%b exp v1 w01101 p1", d0_out_valid, d0_out_word, d0_out_parity);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (d0_out_valid !== 1'b0 || d0_frame_cnt !== 8'd1) begin
            errors++; $display("FAIL single_done got v%b cnt%0d exp v0 cnt1", d0_out_valid, d0_frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] bits;
        logic [4:0]  w;
        bits = 20'($urandom);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(bits[i], 1'b1, 1'b0, 1'b1, 1'b0);
            checks++;
            if (rdy_obs0 !== 1'b1) begin
                errors++; $display("FAIL b2b_ready i=%0d got %b exp 1", i, rdy_obs0);
            end
            if (i % 5 == 4) begin
                w = bits[i-4 +: 5];
                checks++;
                if (d0_out_valid !== 1'b1 || d0_out_word !== w || d0_out_parity !== (w[0]^w[1]^w[2]^w[3]^w[4])) begin
                    errors++; $display("FAIL b2b_frame i=%0d got v%b w%b p%b exp v1 w%b", i, d0_out_valid, d0_out_word, d0_out_parity, w);
                end
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (d0_frame_cnt !== 8'd4 || d0_out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_count got %0d v%b exp 4 v0", d0_frame_cnt, d0_out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] a, b;
        a = 5'($urandom); b = 5'($urandom);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step(a[k], 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(b[k], 1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (rdy_obs0 !== 1'b1) begin
                errors++; $display("FAIL bp_overlap k=%0d got %b exp 1", k, rdy_obs0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            step(b[4], 1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (rdy_obs0 !== 1'b0 || d0_out_word !== a || d0_out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_stall got rdy%b w%b exp rdy0 w%b", rdy_obs0, d0_out_word, a);
            end
        end
        step(b[4], 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (rdy_obs0 !== 1'b1 || d0_out_valid !== 1'b1 || d0_out_word !== b || d0_frame_cnt !== 8'd1) begin
            errors++; $display("FAIL bp_release got rdy%b v%b w%b cnt%0d exp rdy1 v1 w%b cnt1", rdy_obs0, d0_out_valid, d0_out_word, d0_frame_cnt, b);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (d0_frame_cnt !== 8'd2 || d0_out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drain got cnt%0d v%b exp cnt2 v0", d0_frame_cnt, d0_out_valid);
        end
    endtask

    task automatic test_flush();
        logic [4:0] c;
        c = 5'($urandom);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (d0_out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_drop got v%b exp 0", d0_out_valid);
        end
        for (int k = 0; k < 5; k++) step(c[k], 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (d0_out_valid !== 1'b1 || d0_out_word !== c) begin
            errors++; $display("FAIL flush_refill got v%b w%b exp v1 w%b", d0_out_valid, d0_out_word, c);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (d0_out_valid !== 1'b1 || d0_out_word !== c || d0_frame_cnt !== 8'd0) begin
            errors++; $display("FAIL flush_hold got v%b w%b cnt%0d exp v1 w%b cnt0", d0_out_valid, d0_out_word, d0_frame_cnt, c);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (d0_out_valid !== 1'b0 || d0_frame_cnt !== 8'd1) begin
            errors++; $display("FAIL flush_deliver got v%b cnt%0d exp v0 cnt1", d0_out_valid, d0_frame_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] d, e;
        d = 5'($urandom) | 5'b00001; e = 5'($urandom);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step(d[k], 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step(d[k], 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({d0_out_valid, d0_out_word, d0_out_parity, d0_frame_cnt} !== 15'd0 || d1_out_parity !== 1'b1 || d1_frame_cnt !== 2'd0) begin
            errors++; $display("FAIL rst_mid got v%b w%b p%b cnt%0d exp all zero", d0_out_valid, d0_out_word, d0_out_parity, d0_frame_cnt);
        end
        for (int k = 0; k < 5; k++) step(e[k], 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (d0_out_valid !== 1'b1 || d0_out_word !== e) begin
            errors++; $display("FAIL rst_mid_next got v%b w%b exp v1 w%b", d0_out_valid, d0_out_word, e);
        end
    endtask

    task automatic test_counter_wrap();
        logic [1:0] tbl [5];
        logic [4:0] w;
        tbl = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 5; f++) begin
            w = 5'($urandom);
            for (int k = 0; k < 5; k++) step(w[k], 1'b1, 1'b0, 1'b1, 1'b0);
            checks++;
            if (d1_out_parity !== ~(w[0]^w[1]^w[2]^w[3]^w[4])) begin
                errors++; $display("FAIL wrap_parity f=%0d got %b w%b", f, d1_out_parity, w);
            end
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (d1_frame_cnt !== tbl[f]) begin
                errors++; $display("FAIL wrap_cnt f=%0d got %0d exp %0d", f, d1_frame_cnt, tbl[f]);
            end
        end
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (d1_out_valid !== 1'b1 || d1_out_word !== 5'd0 || d1_out_parity !== 1'b1 || d0_out_parity !== 1'b0) begin
            errors++; $display("FAIL odd_zero got v%b w%b p1=%b p0=%b exp v1 w0 p1=1 p0=0", d1_out_valid, d1_out_word, d1_out_parity, d0_out_parity);
        end
    endtask

    task automatic test_random();
        logic r, f;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) < 2);
            f = ($urandom_range(0, 99) < 8);
            step(1'($urandom), 1'($urandom), f, ($urandom_range(0, 3) != 0), r);
            checks++;
            if (rdy_obs0 !== rdy_exp || rdy_obs1 !== rdy_exp) begin
                errors++; $display("FAIL rand_ready i=%0d got %b%b exp %b", i, rdy_obs0, rdy_obs1, rdy_exp);
            end
            checks++;
            if ({d0_out_valid, d0_out_word, d0_out_parity, d0_frame_cnt} !== {m_valid, m_word, ^m_word, m_cnt[7:0]}) begin
                errors++; $display("FAIL rand_d0 i=%0d got %h exp %h", i, {d0_out_valid, d0_out_word, d0_out_parity, d0_frame_cnt}, {m_valid, m_word, ^m_word, m_cnt[7:0]});
            end
            checks++;
            if ({d1_out_valid, d1_out_word, d1_out_parity, d1_frame_cnt} !== {m_valid, m_word, ~(^m_word), m_cnt[1:0]}) begin
                errors++; $display("FAIL rand_d1 i=%0d got %h exp %h", i, {d1_out_valid, d1_out_word, d1_out_parity, d1_frame_cnt}, {m_valid, m_word, ~(^m_word), m_cnt[1:0]});
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_counter_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor5_frame_assembler.md
XOR5_FRAME_ASSEMBLER -- requirements
Module: xor5_frame_assembler

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the delivered-frame counter.
REQ-002 SHALL have parameter ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_bit, input, 1 bit: serial data bit.
REQ-006 SHALL have port in_valid, input, 1 bit: in_bit is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts in_bit this cycle.
REQ-008 SHALL have port flush, input, 1 bit: discard the partial frame.
REQ-009 SHALL have port out_word, output, 5 bits: the assembled frame, feeding the downstream 5-input parity stage as pi0..pi4 = out_word[0..4].
REQ-010 SHALL have port out_parity, output, 1 bit: XOR of out_word[4:0] XOR ODD.
REQ-011 SHALL have port out_valid, output, 1 bit: out_word and out_parity are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the frame.
REQ-013 SHALL have port frame_cnt, output, CNT_W bits: count of delivered frames.

Function
REQ-014 SHALL treat an input accept as in_valid & in_ready, and an output accept as out_valid & out_ready, both sampled at the rising edge of clk.
REQ-015 SHALL hold the collect index bit_idx (0..4) and the shift store sr[3:0]; the bit accepted at index k SHALL go to out_word[k], so the first bit of a frame is out_word[0].
REQ-016 SHALL drive in_ready = 1 while bit_idx < 4, and in_ready = (!out_valid | out_ready) when bit_idx == 4; collection of the next frame SHALL overlap a held output, and only the fifth bit stalls.
REQ-017 On an input accept with bit_idx < 4, the block SHALL store the bit at sr[bit_idx] and increment bit_idx.
REQ-018 On an input accept with bit_idx == 4, the block SHALL load out_word = {in_bit, sr[3:0]}, load out_parity, set out_valid = 1 on the next cycle, and set bit_idx = 0.
REQ-019 Latency SHALL be 1 cycle from the fifth-bit accept to out_valid = 1.
REQ-020 out_word and out_parity SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-021 On an output accept with no simultaneous fifth-bit accept, the block SHALL clear out_valid on the next cycle.
REQ-022 On an output accept in the same cycle as a fifth-bit accept, out_valid SHALL stay 1 and the new frame SHALL replace the old one with no bubble, giving a sustained rate of 1 frame per 5 cycles.
REQ-023 frame_cnt SHALL increment by 1 on each output accept and SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-024 flush = 1 SHALL set bit_idx = 0 next cycle and SHALL leave sr unchanged; any input accept in that same cycle SHALL be discarded, so flush takes priority over the input.
REQ-025 flush SHALL NOT affect out_valid, out_word, out_parity or frame_cnt; a held frame is still delivered.
REQ-026 in_ready SHALL be computed from state and out_ready only, never from in_valid, so there is no combinational loop.
REQ-027 out_parity SHALL be registered together with out_word.

Reset
REQ-028 rst = 1 at a clock edge SHALL set bit_idx = 0, sr = 0, out_word = 0, out_parity = ODD, out_valid = 0 and frame_cnt = 0.
REQ-029 rst SHALL take priority over flush, input accepts and output accepts in the same cycle.
REQ-030 Reset mid-frame or with out_valid = 1 SHALL drop all partial and held data without delivering it.
REQ-031 While rst = 1, in_ready SHALL read 1 (bit_idx = 0 after the first reset edge), but no accept SHALL take effect.

Verification
REQ-032 SHALL cover a single frame: bits 1,0,1,1,0 with in_valid = 1 and out_ready = 1 -> out_word = 5'b01101, out_parity = 1 (ODD = 0), out_valid high for 1 cycle, frame_cnt = 1.
REQ-033 SHALL cover back-to-back frames: 20 bits streamed, out_ready = 1 -> 4 frames, in_ready never low, frame_cnt = 4, and each out_parity matches an independent 5-input XOR model.
REQ-034 SHALL cover backpressure: out_ready = 0 after frame A -> the next 4 bits are accepted, in_ready = 0 at the fifth bit, and out_word holds A; raising out_ready -> A is taken and frame B appears the next cycle with no lost bit.
REQ-035 SHALL cover flush: flush at bit_idx = 3 together with in_valid -> that bit is dropped, and the next 5 bits form the frame; flush with out_valid = 1 -> the held frame is still delivered.
REQ-036 SHALL cover reset mid-operation: rst with bit_idx = 2 and out_valid = 1 -> all outputs reach reset values next cycle and frame_cnt = 0.
REQ-037 SHALL cover counter wrap: CNT_W = 2 with 5 frames -> frame_cnt reads 1,2,3,0,1; ODD = 1 with word 0 -> out_parity = 1.
